usb_fs_rx: RTL and testbench

Device-side USB full-speed (12 Mb/s) packet receiver. Clocked at 48 MHz, it oversamples the raw D+/D- pair 4x and recovers bit timing from line transitions. It then NRZI-decodes, detects SYNC, removes stuffed bits, detects EOP and bus reset, and delivers packet bytes LSB-first to the protocol engine in `top`. It is the device counterpart of the host bench's packet sender.

---
 rtl/usb_fs_rx_if.sv | 13 +
 rtl/usb_fs_rx.sv | 188 ++++++++++++++++++
 tb/tb_usb_fs_rx.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fs_rx_if.sv
// Receive-side bus from the USB full-speed receiver to the protocol engine.
interface usb_fs_rx_if;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_end;
    logic       rx_error;
    logic       pid_error;
    logic       bus_reset;

    modport master (output rx_active, rx_data, rx_valid, rx_end, rx_error, pid_error, bus_reset);
    modport slave  (input  rx_active, rx_data, rx_valid, rx_end, rx_error, pid_error, bus_reset);
endinterface

// File: rtl/usb_fs_rx.sv
// USB full-speed device receiver: 4x oversampled bit recovery, NRZI, SYNC, destuff, EOP, bus reset.
// Optional PID check on the first byte is built when USB_RX_PID_CHECK_EN is defined.
module usb_fs_rx #(
    parameter int RESET_SE0_CYCLES = 120,
    parameter int SYNC_MIN_ZEROS   = 3
) (
    input  logic        clock48,
    input  logic        reset_n,
    input  logic        usb_dp,
    input  logic        usb_dn,
    usb_fs_rx_if.master rx
);
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam logic [7:0] SE0_LAST = 8'(RESET_SE0_CYCLES - 1);
    localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERR_WAIT} state_e;

    logic [1:0] meta_q, line_q, prev_q, smp_q;
    logic [1:0] phase_q, phase_d;
    logic       sample, bit_d, take_bit;
    logic [7:0] se0_cnt_q;
    logic       bus_reset_q;
    state_e     state_q;
    logic [2:0] zero_cnt_q, ones_cnt_q, bit_cnt_q, j_cnt_q;
    logic       byte_seen_q, se0_seen_q;
    logic [7:0] shift_q, shift_d;
    logic       rx_active_q, rx_valid_q, rx_end_q, rx_error_q;

    // Phase restarts on every line transition so the sample lands mid-bit.
    assign phase_d  = (line_q != prev_q) ? 2'd0 : phase_q + 2'd1;
    assign sample   = (phase_d == 2'd2);
    assign bit_d    = (line_q == smp_q);
    assign shift_d  = {bit_d, shift_q[7:1]};
    assign take_bit = sample && !bus_reset_q && (state_q == S_DATA) &&
                      (line_q[1] ^ line_q[0]) && (ones_cnt_q != 3'd6);

    always_ff @(posedge clock48) begin
        if (!reset_n) begin
            meta_q  <= LS_J;
            line_q  <= LS_J;
            prev_q  <= LS_J;
            phase_q <= 2'd0;
        end else begin
            meta_q  <= {usb_dp, usb_dn};
            line_q  <= meta_q;
            prev_q  <= line_q;
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clock48) begin
        if (!reset_n) begin
            se0_cnt_q   <= 8'd0;
            bus_reset_q <= 1'b0;
        end else if (line_q == LS_SE0) begin
            if (se0_cnt_q != 8'hFF) se0_cnt_q <= se0_cnt_q + 8'd1;
            if (se0_cnt_q >= SE0_LAST) bus_reset_q <= 1'b1;
        end else begin
            se0_cnt_q   <= 8'd0;
            bus_reset_q <= 1'b0;
        end
    end

    always_ff @(posedge clock48) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            smp_q       <= LS_J;
            zero_cnt_q  <= 3'd0;
            ones_cnt_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            j_cnt_q     <= 3'd0;
            byte_seen_q <= 1'b0;
            se0_seen_q  <= 1'b0;
            shift_q     <= 8'd0;
            rx_active_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_end_q    <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_end_q   <= 1'b0;
            rx_error_q <= 1'b0;
            if (rx_end_q) rx_active_q <= 1'b0;
            if (sample) smp_q <= line_q;
            if (bus_reset_q) begin
                state_q     <= S_IDLE;
                rx_active_q <= 1'b0;
            end else if (sample) begin
                case (state_q)
                    S_IDLE: if (line_q == LS_K) begin
                        state_q    <= S_SYNC;
                        zero_cnt_q <= 3'd1;
                    end
                    S_SYNC: begin
                        if (line_q == LS_SE0 || line_q == LS_SE1) begin
                            state_q <= S_IDLE;
                        end else if (!bit_d) begin
                            if (zero_cnt_q != 3'd7) zero_cnt_q <= zero_cnt_q + 3'd1;
                        end else if (zero_cnt_q >= SYNC_MIN) begin
                            state_q     <= S_DATA;
                            rx_active_q <= 1'b1;
                            ones_cnt_q  <= 3'd1;
                            bit_cnt_q   <= 3'd0;
                            byte_seen_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        if (line_q == LS_SE0) begin
                            rx_end_q   <= 1'b1;
                            rx_error_q <= (bit_cnt_q != 3'd0) || !byte_seen_q;
                            state_q    <= S_EOP;
                        end else if (line_q == LS_SE1 || (ones_cnt_q == 3'd6 && bit_d)) begin
                            rx_end_q   <= 1'b1;
                            rx_error_q <= 1'b1;
                            state_q    <= S_ERR_WAIT;
                            j_cnt_q    <= 3'd0;
                            se0_seen_q <= 1'b0;
                        end else if (ones_cnt_q == 3'd6) begin
                            ones_cnt_q <= 3'd0;
                        end else begin
                            shift_q    <= shift_d;
                            ones_cnt_q <= bit_d ? ones_cnt_q + 3'd1 : 3'd0;
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_valid_q  <= 1'b1;
                                byte_seen_q <= 1'b1;
                            end
                        end
                    end
                    S_EOP: begin
                        if (line_q == LS_J) begin
                            state_q <= S_IDLE;
                        end else if (line_q != LS_SE0) begin
                            state_q    <= S_ERR_WAIT;
                            j_cnt_q    <= 3'd0;
                            se0_seen_q <= 1'b0;
                        end
                    end
                    S_ERR_WAIT: begin
                        case (line_q)
                            LS_SE0: begin
                                se0_seen_q <= 1'b1;
                                j_cnt_q    <= 3'd0;
                            end
                            LS_J: begin
                                if (se0_seen_q || j_cnt_q == 3'd7) state_q <= S_IDLE;
                                else j_cnt_q <= j_cnt_q + 3'd1;
                            end
                            default: j_cnt_q <= 3'd0;
                        endcase
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef USB_RX_PID_CHECK_EN
    logic pid_err_q;

    // Held from the failing first byte until the packet's end pulse has been seen.
    always_ff @(posedge clock48) begin
        if (!reset_n || bus_reset_q || rx_end_q) begin
            pid_err_q <= 1'b0;
        end else if (take_bit && bit_cnt_q == 3'd7 && !byte_seen_q &&
                     shift_d[7:4] != ~shift_d[3:0]) begin
            pid_err_q <= 1'b1;
        end
    end

    assign rx.pid_error = pid_err_q;
`else
    assign rx.pid_error = 1'b0;
`endif

    assign rx.rx_active = rx_active_q;
    assign rx.rx_data   = shift_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.rx_end    = rx_end_q;
    assign rx.rx_error  = rx_error_q;
    assign rx.bus_reset = bus_reset_q;
endmodule

// File: tb/tb_usb_fs_rx.sv
// Bench for usb_fs_rx: host-side NRZI/stuffing packet generator with a pulse scoreboard.
module tb_usb_fs_rx;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam int CLK_HALF = 1250;
    localparam int BIT_NOM  = 10000;
    localparam int BIT_SLOW = 10025;
`ifdef USB_RX_PID_CHECK_EN
    localparam bit PID_ON = 1'b1;
`else
    localparam bit PID_ON = 1'b0;
`endif

    typedef struct packed {
        logic       is_end;
        logic [7:0] data;
        logic       err;
        logic       pid;
    } ev_t;
    typedef logic [7:0] bytes_t[$];

    logic clock48 = 1'b0;
    logic reset_n = 1'b0;
    logic usb_dp  = 1'b1;
    logic usb_dn  = 1'b0;

    usb_fs_rx_if rx_if();

    usb_fs_rx dut (
        .clock48 (clock48),
        .reset_n (reset_n),
        .usb_dp  (usb_dp),
        .usb_dn  (usb_dn),
        .rx      (rx_if)
    );

    always #(CLK_HALF) clock48 = ~clock48;

    ev_t        sb[$];
    logic [1:0] tx_q[$];
    logic [1:0] lvl;
    int         ones;
    bit         bad_pending;
    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    ev_t        mon_got, mon_exp;

    // Every rx_valid / rx_end pulse must match the head of the scoreboard.
    always @(negedge clock48) begin
        if (mon_en && (rx_if.rx_valid || rx_if.rx_end)) begin
            tests++;
            if (rx_if.rx_valid && rx_if.rx_end) begin
                fails++;
                $display("FAIL valid_end_overlap: both pulses high together");
            end
            mon_got = {rx_if.rx_end, rx_if.rx_end ? 8'h00 : rx_if.rx_data,
                       rx_if.rx_end & rx_if.rx_error, rx_if.rx_end & rx_if.pid_error};
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got %h, none expected", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if ({rx_if.rx_active, mon_got} !== {1'b1, mon_exp})
                    begin
                    fails++;
                    $display("FAIL pulse: got active=%b ev=%h, expected active=1 ev=%h",
                             rx_if.rx_active, mon_got, mon_exp);
                end
            end
        end
    end

    task automatic toggle();
        lvl = (lvl == J) ? K : J;
    endtask

    task automatic put_bit(input logic b);
        if (!b) toggle();
        tx_q.push_back(lvl);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            if (!bad_pending) toggle();
            bad_pending = 1'b0;
            tx_q.push_back(lvl);
            ones = 0;
        end
    endtask

    task automatic build_pkt(input bytes_t bytes, input int nbits, input bit bad);
        logic [7:0] by;
        tx_q.delete();
        lvl = J;
        ones = 0;
        bad_pending = bad;
        for (int i = 0; i < 8; i++) put_bit(i == 7);
        for (int i = 0; i < nbits; i++) begin
            by = bytes[i / 8];
            put_bit(by[i % 8]);
        end
        tx_q.push_back(SE0);
        tx_q.push_back(SE0);
        repeat (4) tx_q.push_back(J);
    endtask

    task automatic expect_pkt(input bytes_t bytes, input int nbits);
        int nb;
        logic [7:0] first;
        logic pid;
        nb = nbits / 8;
        for (int i = 0; i < nb; i++) sb.push_back({1'b0, bytes[i], 1'b0, 1'b0});
        first = (nb > 0) ? bytes[0] : 8'h00;
        pid = PID_ON && (nb > 0) && (first[7:4] != ~first[3:0]);
        sb.push_back({1'b1, 8'h00, (nbits % 8 != 0) || (nb == 0), pid});
    endtask

    task automatic drive_tx(input int bit_t);
        foreach (tx_q[i]) begin
            {usb_dp, usb_dn} = tx_q[i];
            #(bit_t);
        end
        {usb_dp, usb_dn} = J;
    endtask

    task automatic drain_check(input string name);
        repeat (60) @(negedge clock48);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d events outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock48);
        #1;
        tests++;
        if ({rx_if.rx_active, rx_if.rx_valid, rx_if.rx_end, rx_if.rx_error,
             rx_if.pid_error, rx_if.bus_reset} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {rx_if.rx_active, rx_if.rx_valid, rx_if.rx_end, rx_if.rx_error,
                      rx_if.pid_error, rx_if.bus_reset});
        end
        tests++;
        if (rx_if.rx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got %h, expected 00", rx_if.rx_data);
        end
        reset_n = 1'b1;
        repeat (20) @(negedge clock48);
    endtask

    task automatic test_ack();
        bytes_t b = '{8'hD2};
        bit saw_act = 1'b0;
        bit saw_end = 1'b0;
        build_pkt(b, 8, 1'b0);
        expect_pkt(b, 8);
        fork
            drive_tx(BIT_NOM);
        join_none
        for (int c = 0; c < 600 && !saw_end; c++) begin
            @(negedge clock48);
            if (rx_if.rx_active) saw_act = 1'b1;
            if (rx_if.rx_end) saw_end = 1'b1;
        end
        tests++;
        if (!saw_end || !saw_act) begin
            fails++;
            $display("FAIL ack_seen: got end=%b active=%b, expected 1 1", saw_end, saw_act);
        end
        @(negedge clock48);
        tests++;
        if (rx_if.rx_active !== 1'b0) begin
            fails++;
            $display("FAIL ack_active_fall: got %b, expected 0", rx_if.rx_active);
        end
        wait fork;
        drain_check("ack");
    endtask

    task automatic test_setup_slow();
        bytes_t b = '{8'hC3, 8'h00, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        build_pkt(b, 72, 1'b0);
        expect_pkt(b, 72);
        drive_tx(BIT_SLOW);
        drain_check("setup");
    endtask

    task automatic test_stuffing();
        bytes_t b = '{8'hFF, 8'hFF};
        build_pkt(b, 16, 1'b0);
        expect_pkt(b, 16);
        drive_tx(BIT_NOM);
        drain_check("stuff_ok");
        build_pkt(b, 16, 1'b1);
        sb.push_back({1'b1, 8'h00, 1'b1, 1'b0});
        drive_tx(BIT_NOM);
        drain_check("stuff_err");
    endtask

    task automatic test_truncated();
        bytes_t b = '{8'h4B, 8'hA5};
        build_pkt(b, 12, 1'b0);
        expect_pkt(b, 12);
        drive_tx(BIT_NOM);
        drain_check("trunc");
    endtask

    task automatic test_pid();
        bytes_t b = '{8'hD3};
        build_pkt(b, 8, 1'b0);
        expect_pkt(b, 8);
        drive_tx(BIT_NOM);
        drain_check("pid");
    endtask

    task automatic test_bus_reset();
        int rise = -1;
        @(negedge clock48);
        {usb_dp, usb_dn} = SE0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clock48);
            #1;
            if (rise < 0 && rx_if.bus_reset === 1'b1) rise = c;
            if (c == 110) begin
                tests++;
                if (rx_if.bus_reset !== 1'b0) begin
                    fails++;
                    $display("FAIL busrst_early: got %b at cycle 110, expected 0", rx_if.bus_reset);
                end
            end
        end
        tests++;
        if (rise < 121 || rise > 123) begin
            fails++;
            $display("FAIL busrst_rise: got cycle %0d, expected 122", rise);
        end
        @(negedge clock48);
        {usb_dp, usb_dn} = J;
        repeat (4) @(posedge clock48);
        #1;
        tests++;
        if (rx_if.bus_reset !== 1'b0) begin
            fails++;
            $display("FAIL busrst_fall: got %b, expected 0", rx_if.bus_reset);
        end
        drain_check("busrst");
    endtask

    task automatic test_mid_reset();
        bytes_t b = '{8'hC3, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        build_pkt(b, 72, 1'b0);
        sb.push_back({1'b0, 8'hC3, 1'b0, 1'b0});
        sb.push_back({1'b0, 8'h55, 1'b0, 1'b0});
        fork
            drive_tx(BIT_NOM);
            begin
                repeat (112) @(posedge clock48);
                #1 reset_n = 1'b0;
                @(posedge clock48);
                #1;
                tests++;
                if ({rx_if.rx_active, rx_if.rx_valid, rx_if.rx_end, rx_if.rx_error,
                     rx_if.pid_error, rx_if.bus_reset, rx_if.rx_data} !== 14'b0) begin
                    fails++;
                    $display("FAIL midrst_outputs: got active=%b data=%h, expected all 0",
                             rx_if.rx_active, rx_if.rx_data);
                end
                reset_n = 1'b1;
            end
        join
        drain_check("midrst");
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_ack();
        test_setup_slow();
        test_stuffing();
        test_truncated();
        test_pid();
        test_bus_reset();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
